// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM state and width defaults for pipe_skid
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int W_DATA_DEF = 32;
    localparam int W_ADDR_DEF = 16;

endpackage

// File: rtl/pipe_skid.sv
// rtl/pipe_skid.sv - two-entry skid buffer with sequence tagging and flush
module pipe_skid
    import pipe_pkg::*;
#(
    parameter  int W_DATA = W_DATA_DEF,
    localparam int W_ADDR = W_ADDR_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              in_valid,
    input  logic [W_DATA-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [W_DATA-1:0] out_data,
    output logic [W_ADDR-1:0] out_seq,
    input  logic              out_ready
);

    state_t            r_state;
    state_t            w_next_state;
    logic [W_DATA-1:0] r_o_data;
    logic [W_ADDR-1:0] r_o_seq;
    logic [W_DATA-1:0] r_s_data;
    logic [W_ADDR-1:0] r_s_seq;
    logic [W_ADDR-1:0] r_seq;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_o;
    logic w_load_s;
    logic w_move_s;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush wins over any handshake seen in the same cycle.
    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_xfer) w_next_state = ONE;
                ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_next_state = TWO;
                    else if (!w_in_xfer && w_out_xfer) w_next_state = EMPTY;
                end
                TWO:     if (w_out_xfer) w_next_state = ONE;
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // in_ready is a pure function of state so out_ready never reaches it.
    always_comb begin
        in_ready  = (r_state != TWO) & ~i_flush;
        out_valid = (r_state != EMPTY);
        w_load_o  = w_in_xfer & ((r_state == EMPTY) | ((r_state == ONE) & w_out_xfer));
        w_load_s  = w_in_xfer & (r_state == ONE) & ~w_out_xfer;
        w_move_s  = w_out_xfer & (r_state == TWO) & ~i_flush;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_o_data <= '0;
            r_o_seq  <= '0;
            r_s_data <= '0;
            r_s_seq  <= '0;
            r_seq    <= '0;
        end else begin
            if (w_load_o) begin
                r_o_data <= in_data;
                r_o_seq  <= r_seq;
            end else if (w_move_s) begin
                r_o_data <= r_s_data;
                r_o_seq  <= r_s_seq;
            end
            if (w_load_s) begin
                r_s_data <= in_data;
                r_s_seq  <= r_seq;
            end
            if (w_in_xfer) begin
                r_seq <= r_seq + {{(W_ADDR-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_data = r_o_data;
    assign out_seq  = r_o_seq;

endmodule

// File: tb/tb_pipe_skid.sv
// tb/tb_pipe_skid.sv - directed and randomized self-checking bench for pipe_skid
module tb_pipe_skid;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic        out_ready;

    int vectors;
    int miscompares;

    pipe_skid dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_flush   (i_flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .out_ready (out_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_reset   = 1'b1;
        i_flush   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        i_reset   = 1'b1;
        i_flush   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
        vectors++;
        if (out_seq !== 16'h0) begin miscompares++; $display("FAIL reset_out_seq got %h want 0", out_seq); end
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_single;
        do_reset();
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got %0b want 1", out_valid); end
        vectors++;
        if (out_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL single_out_data got %h want a5a50001", out_data); end
        vectors++;
        if (out_seq !== 16'h0) begin miscompares++; $display("FAIL single_out_seq got %h want 0", out_seq); end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_one got %0b want 1", in_ready); end
        step();
        in_data = 32'h33;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_two got %0b want 0", in_ready); end
        step();
        vectors++;
        if (out_data !== 32'h11 || out_seq !== 16'd0) begin
            miscompares++; $display("FAIL bp_stall got %h/%0d want 11/0", out_data, out_seq);
        end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_held got %0b want 0", in_ready); end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_data !== 32'h22 || out_seq !== 16'd1) begin
            miscompares++; $display("FAIL bp_second got %h/%0d want 22/1", out_data, out_seq);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h33 || out_seq !== 16'd2) begin
            miscompares++; $display("FAIL bp_third got %0b/%h/%0d want 1/33/2", out_valid, out_data, out_seq);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_seq;
        int          bad;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_seq   = 16'h0;
        bad       = 0;
        for (int i = 0; i < 70000; i++) begin
            in_data = i;
            if (in_ready !== 1'b1 && bad < 10) begin
                bad++; miscompares++; $display("FAIL b2b_in_ready word %0d got %0b want 1", i, in_ready);
            end
            vectors++;
            step();
            vectors++;
            if ((out_valid !== 1'b1 || out_data !== 32'(i) || out_seq !== exp_seq) && bad < 10) begin
                bad++; miscompares++;
                $display("FAIL b2b_word %0d got %0b/%h/%h want 1/%h/%h", i, out_valid, out_data, out_seq, 32'(i), exp_seq);
            end
            exp_seq = exp_seq + 16'd1;
        end
        in_valid = 1'b0;
        vectors++;
        if (out_seq !== 16'd4463) begin miscompares++; $display("FAIL b2b_wrap got %h want 116f", out_seq); end
        step();
    endtask

    task automatic test_flush;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        step();
        in_data = 32'h2;
        step();
        i_flush = 1'b1;
        in_data = 32'h3;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        step();
        i_flush = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_after got %0b want 1", in_ready); end
        in_data   = 32'h4;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h4 || out_seq !== 16'd2) begin
            miscompares++; $display("FAIL flush_next got %0b/%h/%0d want 1/4/2", out_valid, out_data, out_seq);
        end
        step();
    endtask

    task automatic test_reset_midcycle;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAA;
        step();
        in_data = 32'hBB;
        step();
        in_valid = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
        vectors++;
        if (out_seq !== 16'h0 || out_data !== 32'h0) begin
            miscompares++; $display("FAIL rstmid_outputs got %h/%h want 0/0", out_data, out_seq);
        end
        i_reset = 1'b0;
        #1;
        in_valid = 1'b1;
        in_data  = 32'h55;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || out_seq !== 16'd0) begin
            miscompares++; $display("FAIL rstmid_next got %0b/%h/%0d want 1/55/0", out_valid, out_data, out_seq);
        end
    endtask

    task automatic test_random;
        logic [31:0] q_data[$];
        logic [15:0] q_seq[$];
        logic [15:0] model_seq;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [15:0] prev_seq;
        logic        in_x;
        logic        out_x;
        int          bad;
        do_reset();
        model_seq  = 16'h0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_seq   = '0;
        bad        = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            vectors++;
            if (in_ready !== (q_data.size() < 2) || out_valid !== (q_data.size() != 0)) begin
                if (bad < 10) $display("FAIL rand_flags cycle %0d got %0b/%0b want %0b/%0b", c,
                                       in_ready, out_valid, q_data.size() < 2, q_data.size() != 0);
                bad++; miscompares++;
            end
            if (q_data.size() != 0) begin
                vectors++;
                if (out_data !== q_data[0] || out_seq !== q_seq[0]) begin
                    if (bad < 10) $display("FAIL rand_order cycle %0d got %h/%h want %h/%h", c,
                                           out_data, out_seq, q_data[0], q_seq[0]);
                    bad++; miscompares++;
                end
            end
            if (prev_stall) begin
                vectors++;
                if (out_data !== prev_data || out_seq !== prev_seq) begin
                    if (bad < 10) $display("FAIL rand_stall cycle %0d got %h/%h want %h/%h", c,
                                           out_data, out_seq, prev_data, prev_seq);
                    bad++; miscompares++;
                end
            end
            in_x       = in_valid && (q_data.size() < 2);
            out_x      = out_ready && (q_data.size() != 0);
            prev_stall = (q_data.size() != 0) && !out_ready;
            prev_data  = out_data;
            prev_seq   = out_seq;
            if (out_x) begin
                void'(q_data.pop_front());
                void'(q_seq.pop_front());
            end
            if (in_x) begin
                q_data.push_back(in_data);
                q_seq.push_back(model_seq);
                model_seq = model_seq + 16'd1;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q_data.size() != 0) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== q_data[0] || out_seq !== q_seq[0]) begin
                miscompares++; $display("FAIL rand_drain got %0b/%h/%h want 1/%h/%h",
                                        out_valid, out_data, out_seq, q_data[0], q_seq[0]);
            end
            void'(q_data.pop_front());
            void'(q_seq.pop_front());
            step();
        end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rand_empty got %0b want 0", out_valid); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midcycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_skid.md
PIPE_SKID -- requirements
Module: pipe_skid

Interface
REQ-001 The block SHALL provide parameter W_DATA, default 32, giving the payload width in bits.
REQ-002 The block SHALL provide parameter W_ADDR, default 16, giving the sequence-tag width in bits; it is not overridable.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: asynchronous reset, active-high.
REQ-005 The block SHALL have port i_flush, input, 1 bit: synchronous discard of all buffered words.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream pipe_pal stage presents a word.
REQ-007 The block SHALL have port in_data, input, W_DATA bits: the upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a word is presented downstream.
REQ-010 The block SHALL have port out_data, output, W_DATA bits: the downstream payload.
REQ-011 The block SHALL have port out_seq, output, W_ADDR bits: the sequence tag of out_data.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.

Function
REQ-013 Transfers SHALL occur only on a rising edge where valid and ready are both 1; in = in_valid & in_ready, out = out_valid & out_ready.
REQ-014 The block SHALL hold two registered entries: an output register (O) and a skid register (S).
REQ-015 The FSM SHALL have three states: EMPTY (no entries), ONE (O valid), TWO (O and S valid).
REQ-016 In EMPTY, an in transfer SHALL load O and move the FSM to ONE.
REQ-017 In ONE, in without out SHALL load S and move to TWO.
REQ-018 In ONE, out without in SHALL move to EMPTY.
REQ-019 In ONE, in and out together SHALL load O with the new word and keep the FSM in ONE.
REQ-020 In TWO, out SHALL move S to O and move to ONE; an out stall SHALL hold both entries unchanged.
REQ-021 in_ready SHALL equal (state != TWO) & ~i_flush and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL equal (state != EMPTY); out_data and out_seq SHALL come directly from O.
REQ-023 out_data and out_seq SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 A W_ADDR-bit counter seq SHALL tag each accepted word with its current value, then increment, wrapping from 2^W_ADDR-1 to 0.
REQ-025 Words SHALL leave in acceptance order with no loss or duplication; latency SHALL be one cycle from acceptance to out_valid when the block is EMPTY.
REQ-026 i_flush=1 SHALL force EMPTY at the next edge; simultaneous in or out that cycle is ignored, and seq is not reset.

Reset
REQ-027 Asserting i_reset SHALL immediately force state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_seq=0, seq=0 and S=0, including during an in-flight transfer.
REQ-028 The first edge after i_reset deasserts SHALL be able to accept a word.

Structure
REQ-029 A shared package pipe_pkg SHALL define the FSM state enum (EMPTY/ONE/TWO) and the default W_DATA and W_ADDR constants.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 Scenario: reset, then in_valid=1 with data 0xA5A5_0001 and out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xA5A5_0001, out_seq=0.
REQ-032 Scenario: out_ready=0 and words 0x11, 0x22, 0x33 offered back-to-back -> 0x11 and 0x22 accepted; in_ready=0 after the second acceptance; 0x33 held upstream; after out_ready=1 the outputs are 0x11, 0x22, 0x33 with seq 0, 1, 2.
REQ-033 Scenario: continuous in_valid=1 and out_ready=1 for 70000 words -> one word per cycle, out_seq wraps from 0xFFFF to 0x0000, no gaps.
REQ-034 Scenario: state TWO, then i_flush=1 with in_valid=1 -> EMPTY next cycle, out_valid=0, the offered word is not accepted, and the next accepted word has seq=2.
REQ-035 Scenario: i_reset pulsed mid-cycle while in state TWO -> out_valid drops immediately, in_ready=1, and the next accepted word has seq=0.
REQ-036 Scenario: random valid/ready toggling for 10k cycles -> a scoreboard sees an in-order, lossless stream; out_data is stable during every stall.
